// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pkg
// Purpose  : Shared RV32I core types and constants (fetch entry record).
// Revision : 1.0  initial release
// ============================================================================
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            misalign;
  } fetch_entry_t;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry synchronous FIFO of fetch entries with flush.
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so push into a full FIFO is legal then.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : RV32I fetch stage: PC, credit-limited I_mem requests, prefetch
//            buffer and redirect handling. Optional FETCH_MISALIGN_TRAP_EN
//            adds a misaligned-redirect trap entry and instr_misalign output.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              instr_misalign
`endif
);

  localparam int CNT_W = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_issue_pc;
  logic             r_inflight;
  logic             r_started;

  logic             w_halted;
  logic             w_trap_pend;
  fetch_entry_t     w_trap_entry;

  fetch_entry_t     w_head;
  fetch_entry_t     w_resp;
  fetch_entry_t     w_out;
  logic             w_empty;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occ;
  logic             w_resp_valid;
  logic             w_pop;
  logic             w_issue;
  logic             w_fifo_push;
  logic             w_fifo_pop;
  logic             w_unused_full;

  // The in-flight response already owns a credit, so it is counted in occupancy.
  assign w_occ = {1'b0, w_count}
               + (CNT_W+1)'(r_inflight)
               + (CNT_W+1)'(w_trap_pend)
               - (CNT_W+1)'(w_pop);

  assign w_issue = r_started && !redirect_valid && !w_halted
                && (w_occ < (CNT_W+1)'(DEPTH));

  assign w_resp_valid = r_inflight || w_trap_pend;

  always_comb begin
    w_resp = '{pc: r_issue_pc, instr: imem_rdata, misalign: 1'b0};
    if (w_trap_pend) begin
      w_resp = w_trap_entry;
    end
  end

  // An arriving response bypasses an empty buffer so decode sees it the same cycle.
  always_comb begin
    w_out = w_head;
    if (w_empty && w_resp_valid) begin
      w_out = w_resp;
    end
  end

  assign instr_valid = !w_empty || w_resp_valid;
  assign instr       = w_out.instr;
  assign instr_pc    = w_out.pc;
  assign imem_req    = w_issue;

  assign w_pop       = instr_valid && instr_ready;
  assign w_fifo_pop  = w_pop && !w_empty;
  assign w_fifo_push = w_resp_valid && !redirect_valid && !(w_empty && w_pop);

  generate
    if (ADDR_W <= 32) begin : g_addr_narrow
      assign imem_addr = r_fetch_pc[ADDR_W-1:0];
    end else begin : g_addr_wide
      assign imem_addr = {{(ADDR_W-32){1'b0}}, r_fetch_pc};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_issue_pc <= '0;
      r_inflight <= 1'b0;
      r_started  <= 1'b0;
    end else begin
      r_started  <= 1'b1;
      // A redirect suppresses issue, so nothing of the old stream is in flight next cycle.
      r_inflight <= w_issue;
      if (w_issue) begin
        r_issue_pc <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        r_halted;
  logic        r_trap_pend;
  logic [31:0] r_trap_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted    <= 1'b0;
      r_trap_pend <= 1'b0;
      r_trap_pc   <= '0;
    end else begin
      r_trap_pend <= 1'b0;
      if (redirect_valid) begin
        r_halted    <= |redirect_pc[1:0];
        r_trap_pend <= |redirect_pc[1:0];
        r_trap_pc   <= redirect_pc;
      end
    end
  end

  assign w_halted       = r_halted;
  assign w_trap_pend    = r_trap_pend;
  assign w_trap_entry   = '{pc: r_trap_pc, instr: NOP_INSTR, misalign: 1'b1};
  assign instr_misalign = w_out.misalign;
  assign w_unused_full  = w_full;
`else
  assign w_halted      = 1'b0;
  assign w_trap_pend   = 1'b0;
  assign w_trap_entry  = '0;
  assign w_unused_full = ^{w_full, w_out.misalign, redirect_pc[1:0]};
`endif

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (w_fifo_push),
    .push_data (w_resp),
    .pop       (w_fifo_pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed self-checking bench for instr_fetch with a 1-cycle ROM.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        instr_misalign;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int n_req  = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH),
    .ADDR_W   (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .instr_misalign (instr_misalign)
`endif
  );

  function automatic logic [31:0] rom_word(input int idx);
    case (idx)
      0:       rom_word = 32'h0140_0093;
      1:       rom_word = 32'h0010_0113;
      2:       rom_word = 32'h4020_80b3;
      default: rom_word = 32'hC000_0000 + 32'(idx);
    endcase
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= rom_word(int'(imem_addr[9:2]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next edge, drive this cycle's inputs, let logic settle.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n          = 1'b0;
    instr_ready    = rdy;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("req_cycle0", 32'(imem_req), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    // Reset state and first three fetches
    instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    rst_n = 1'b1;
    #1;
    chk("t1_req_c0", 32'(imem_req), 0);
    step(1, 0, 0);
    chk("t1_req_c1", 32'(imem_req), 1);
    chk("t1_addr_c1", imem_addr, 32'h0);
    chk("t1_valid_c1", 32'(instr_valid), 0);
    step(1, 0, 0);
    chk("t1_addr_c2", imem_addr, 32'h4);
    chk("t1_valid_c2", 32'(instr_valid), 1);
    chk("t1_pc_c2", instr_pc, 32'h0);
    chk("t1_instr_c2", instr, 32'h0140_0093);
    step(1, 0, 0);
    chk("t1_addr_c3", imem_addr, 32'h8);
    chk("t1_pc_c3", instr_pc, 32'h4);
    chk("t1_instr_c3", instr, 32'h0010_0113);
    step(1, 0, 0);
    chk("t1_pc_c4", instr_pc, 32'h8);
    chk("t1_instr_c4", instr, 32'h4020_80b3);

    // Stall: credit limit and stable outputs, then lossless resume
    do_reset(1'b0);
    n_req = 0;
    for (int c = 1; c <= 6; c++) begin
      step(0, 0, 0);
      n_req += int'(imem_req);
      if (c >= 2) begin
        chk("t2_stall_valid", 32'(instr_valid), 1);
        chk("t2_stall_pc", instr_pc, 32'h0);
        chk("t2_stall_instr", instr, 32'h0140_0093);
      end
    end
    chk("t2_req_count", 32'(n_req), DEPTH);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0);
      chk("t2_res_valid", 32'(instr_valid), 1);
      chk("t2_res_pc", instr_pc, 32'(4 * k));
      chk("t2_res_instr", instr, rom_word(k));
    end

    // Redirect with one entry buffered and one request in flight
    do_reset(1'b0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 32'h18);
    chk("t3_req_n", 32'(imem_req), 0);
    chk("t3_pc_n", instr_pc, 32'h0);
    step(1, 0, 0);
    chk("t3_req_n1", 32'(imem_req), 1);
    chk("t3_addr_n1", imem_addr, 32'h18);
    chk("t3_valid_n1", 32'(instr_valid), 0);
    step(1, 0, 0);
    chk("t3_valid_n2", 32'(instr_valid), 1);
    chk("t3_pc_n2", instr_pc, 32'h18);
    chk("t3_instr_n2", instr, rom_word(6));
    step(1, 0, 0);
    chk("t3_pc_n3", instr_pc, 32'h1C);

    // Back-to-back redirects: last one wins
    step(1, 1, 32'h10);
    step(1, 1, 32'h20);
    chk("t4_req_2nd", 32'(imem_req), 0);
    chk("t4_valid_2nd", 32'(instr_valid), 0);
    step(1, 0, 0);
    chk("t4_addr", imem_addr, 32'h20);
    chk("t4_valid_gap", 32'(instr_valid), 0);
    step(1, 0, 0);
    chk("t4_pc_first", instr_pc, 32'h20);
    chk("t4_instr_first", instr, rom_word(8));
    step(1, 0, 0);
    chk("t4_pc_next", instr_pc, 32'h24);

    // Asynchronous reset mid-stream
    step(1, 0, 0);
    chk("t5_pre_pc", instr_pc, 32'h28);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(instr_valid), 0);
    chk("t5_async_instr", instr, 0);
    chk("t5_async_pc", instr_pc, 0);
    chk("t5_async_req", 32'(imem_req), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t5_req_c0", 32'(imem_req), 0);
    step(1, 0, 0);
    chk("t5_addr_c1", imem_addr, 32'h0);
    chk("t5_req_c1", 32'(imem_req), 1);
    step(1, 0, 0);
    chk("t5_pc_c2", instr_pc, 32'h0);
    chk("t5_instr_c2", instr, 32'h0140_0093);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect produces one trap entry and halts fetch
    step(1, 1, 32'h0A);
    step(1, 0, 0);
    chk("t6_valid", 32'(instr_valid), 1);
    chk("t6_pc", instr_pc, 32'h0A);
    chk("t6_instr", instr, 32'h0000_0013);
    chk("t6_misalign", 32'(instr_misalign), 1);
    chk("t6_req_a", 32'(imem_req), 0);
    step(1, 0, 0);
    chk("t6_valid_after", 32'(instr_valid), 0);
    chk("t6_req_b", 32'(imem_req), 0);
    step(1, 0, 0);
    chk("t6_req_c", 32'(imem_req), 0);
    step(1, 1, 32'h0);
    step(1, 0, 0);
    chk("t6_resume_req", 32'(imem_req), 1);
    chk("t6_resume_addr", imem_addr, 32'h0);
    step(1, 0, 0);
    chk("t6_resume_pc", instr_pc, 32'h0);
    chk("t6_resume_instr", instr, 32'h0140_0093);
    chk("t6_resume_mis", 32'(instr_misalign), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire
